// File: rtl/game_sequencer.sv
// Frame-based round controller for the paddle/ball game: attract, serve countdown,
// play, miss pause and game-over display, with lives and a saturating score.
module game_sequencer #(
    parameter int LIVES           = 3,
    parameter int SERVE_FRAMES    = 60,
    parameter int MISS_FRAMES     = 64,
    parameter int GAMEOVER_FRAMES = 128,
    parameter int SCORE_W         = 8
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic               obj_rst,
    output logic               obj_freeze,
    output logic               paddle_rst,
    output logic               show_gameover,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ATTRACT  = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        MISS     = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [7:0]         SERVE_LAST    = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]         MISS_LAST     = 8'(MISS_FRAMES - 1);
    localparam logic [7:0]         GAMEOVER_LAST = 8'(GAMEOVER_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX     = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE     = 1;

    state_t             state_reg;
    logic [7:0]         frame_cnt_reg;
    logic               armed_reg;
    logic [2:0]         lives_reg;
    logic [SCORE_W-1:0] score_reg;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_reg     <= ATTRACT;
            frame_cnt_reg <= 8'd0;
            armed_reg     <= 1'b0;
            lives_reg     <= 3'(LIVES);
            score_reg     <= '0;
        end else begin
            case (state_reg)
                ATTRACT: begin
                    // A release must be seen before a press starts a game
                    if (armed_reg && start) begin
                        state_reg     <= SERVE;
                        frame_cnt_reg <= 8'd0;
                        lives_reg     <= 3'(LIVES);
                        score_reg     <= '0;
                    end else if (!start) begin
                        armed_reg <= 1'b1;
                    end
                end
                SERVE: begin
                    if (fsync) begin
                        if (frame_cnt_reg == SERVE_LAST) begin
                            state_reg     <= PLAY;
                            frame_cnt_reg <= 8'd0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                end
                PLAY: begin
                    if (hit && score_reg != SCORE_MAX)
                        score_reg <= score_reg + SCORE_ONE;
                    if (miss) begin
                        state_reg     <= MISS;
                        frame_cnt_reg <= 8'd0;
                    end
                end
                MISS: begin
                    if (fsync) begin
                        if (frame_cnt_reg == MISS_LAST) begin
                            frame_cnt_reg <= 8'd0;
                            lives_reg     <= lives_reg - 3'd1;
                            state_reg     <= (lives_reg == 3'd1) ? GAMEOVER : SERVE;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                end
                GAMEOVER: begin
                    // Score and lives are left untouched so the overlay can show them
                    if (fsync) begin
                        if (frame_cnt_reg == GAMEOVER_LAST) begin
                            state_reg     <= ATTRACT;
                            frame_cnt_reg <= 8'd0;
                            armed_reg     <= 1'b0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg     <= ATTRACT;
                    frame_cnt_reg <= 8'd0;
                    armed_reg     <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        obj_rst       = 1'b1;
        obj_freeze    = 1'b1;
        paddle_rst    = 1'b1;
        show_gameover = 1'b0;
        case (state_reg)
            SERVE: begin
                paddle_rst = 1'b0;
            end
            PLAY: begin
                obj_rst    = 1'b0;
                obj_freeze = 1'b0;
                paddle_rst = 1'b0;
            end
            MISS: begin
                obj_rst    = 1'b0;
                paddle_rst = 1'b0;
            end
            GAMEOVER: begin
                obj_rst       = 1'b0;
                paddle_rst    = 1'b0;
                show_gameover = 1'b1;
            end
            default: ;
        endcase
    end

    assign lives = lives_reg;
    assign score = score_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed round walk-through followed by
// randomized inputs, compared every cycle against a frames-remaining countdown model.
module tb_game_sequencer;

    localparam int LIVES = 2;
    localparam int SERVE_FRAMES = 2;
    localparam int MISS_FRAMES = 2;
    localparam int GAMEOVER_FRAMES = 3;
    localparam int SCORE_W = 4;
    localparam int SCORE_TOP = (1 << SCORE_W) - 1;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b0;
    logic               fsync = 1'b0;
    logic               start = 1'b0;
    logic               hit = 1'b0;
    logic               miss = 1'b0;
    logic               obj_rst;
    logic               obj_freeze;
    logic               paddle_rst;
    logic               show_gameover;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [2:0]         state;

    int checks = 0;
    int failures = 0;

    // Reference model: phase number, frames still to wait, lives, score, armed flag
    int m_phase;
    int m_left;
    int m_lives;
    int m_score;
    bit m_armed;

    game_sequencer #(
        .LIVES(LIVES),
        .SERVE_FRAMES(SERVE_FRAMES),
        .MISS_FRAMES(MISS_FRAMES),
        .GAMEOVER_FRAMES(GAMEOVER_FRAMES),
        .SCORE_W(SCORE_W)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .fsync(fsync),
        .start(start),
        .hit(hit),
        .miss(miss),
        .obj_rst(obj_rst),
        .obj_freeze(obj_freeze),
        .paddle_rst(paddle_rst),
        .show_gameover(show_gameover),
        .lives(lives),
        .score(score),
        .state(state)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // obj_rst, obj_freeze, paddle_rst, show_gameover
    function automatic logic [3:0] expected_outs(input int phase);
        case (phase)
            1: return 4'b1100;
            2: return 4'b0000;
            3: return 4'b0100;
            4: return 4'b0101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input bit f, input bit h, input bit m);
        if (r) begin
            m_phase = 0; m_left = 0; m_lives = LIVES; m_score = 0; m_armed = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (m_armed && s) begin
                    m_phase = 1; m_left = SERVE_FRAMES; m_lives = LIVES; m_score = 0;
                end else if (!s) begin
                    m_armed = 1;
                end
            end
            2: begin
                if (h && m_score < SCORE_TOP) m_score++;
                if (m) begin
                    m_phase = 3; m_left = MISS_FRAMES;
                end
            end
            default: begin
                if (f) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_phase == 1) begin
                            m_phase = 2;
                        end else if (m_phase == 3) begin
                            m_lives--;
                            if (m_lives == 0) begin
                                m_phase = 4; m_left = GAMEOVER_FRAMES;
                            end else begin
                                m_phase = 1; m_left = SERVE_FRAMES;
                            end
                        end else begin
                            m_phase = 0; m_armed = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic cyc(input bit r, input bit s, input bit f, input bit h, input bit m);
        @(negedge pixel_clk);
        rst = r; start = s; fsync = f; hit = h; miss = m;
        @(posedge pixel_clk);
        model_step(r, s, f, h, m);
        #1;
        $display("cyc rst=%0b start=%0b fsync=%0b hit=%0b miss=%0b -> state=%0d lives=%0d score=%0d outs=%b",
                 r, s, f, h, m, state, lives, score,
                 {obj_rst, obj_freeze, paddle_rst, show_gameover});
        check_val("state", 32'(state), 32'(m_phase));
        check_val("lives", 32'(lives), 32'(m_lives));
        check_val("score", 32'(score), 32'(m_score));
        check_val("outs", 32'({obj_rst, obj_freeze, paddle_rst, show_gameover}),
                  32'(expected_outs(m_phase)));
    endtask

    initial begin
        // Reset with start held, then frames in ATTRACT must not start a game
        cyc(1, 1, 0, 0, 0);
        check_val("reset_outs", 32'({obj_rst, obj_freeze, paddle_rst, show_gameover}), 32'h0000_000e);
        repeat (3) cyc(0, 1, 1, 0, 0);
        check_val("held_start_state", 32'(state), 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check_val("serve_entry_state", 32'(state), 32'd1);
        check_val("serve_paddle_rst", 32'(paddle_rst), 32'd0);

        // SERVE: entry-cycle fsync ignored, noise pulses ignored, two counted frames
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 1);
        check_val("serve_hold", 32'(state), 32'd1);
        cyc(0, 0, 1, 0, 0);
        check_val("play_state", 32'(state), 32'd2);

        // PLAY: score saturation, then coincident hit and miss
        repeat (17) cyc(0, 0, 1, 1, 0);
        check_val("score_sat", 32'(score), 32'd15);
        cyc(0, 0, 0, 1, 1);
        check_val("miss_state", 32'(state), 32'd3);
        check_val("miss_freeze", 32'(obj_freeze), 32'd1);

        // First miss pause, with noise pulses
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 0, 0);
        check_val("lives_after_miss1", 32'(lives), 32'd1);
        check_val("serve_again", 32'(state), 32'd1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_val("gameover_state", 32'(state), 32'd4);
        check_val("lives_zero", 32'(lives), 32'd0);

        // GAMEOVER: noise pulses, three counted frames, score retained
        cyc(0, 1, 0, 1, 1);
        repeat (2) cyc(0, 0, 1, 1, 0);
        check_val("overlay_on", 32'(show_gameover), 32'd1);
        cyc(0, 0, 1, 0, 0);
        check_val("back_to_attract", 32'(state), 32'd0);
        check_val("score_retained", 32'(score), 32'd15);

        // Reset in the middle of a miss countdown
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check_val("midcount_rst_state", 32'(state), 32'd0);
        check_val("midcount_rst_lives", 32'(lives), 32'd2);
        check_val("midcount_rst_score", 32'(score), 32'd0);
        check_val("midcount_rst_objrst", 32'(obj_rst), 32'd1);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
